jtframe_ddram_resp: RTL and testbench

- Responder (slave) end of the jtframe ddram_* burst interface driven by the line-frame buffer initiator.
- Backs the interface with on-chip byte-enabled BRAM instead of external DDR3.
- Lets DECA LF_BUFFER builds run and verify before the DDR3 controller is wired, and serves as the bench model for initiators.

---
 rtl/jtframe_ddram_pkg.sv | 13 +
 rtl/jtframe_ddram_bram.sv | 22 ++
 rtl/jtframe_ddram_resp.sv | 170 +++++++++++++++++
 tb/tb_jtframe_ddram_resp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_ddram_pkg.sv
// Shared types and helpers for the BRAM-backed ddram_* responder.
package jtframe_ddram_pkg;

    localparam int BURSTW = 8;

    typedef enum logic [1:0] {IDLE, WR, RD, WT} ddram_st_e;

    // A burst count of zero means a single beat.
    function automatic logic [BURSTW-1:0] norm_burst(input logic [BURSTW-1:0] cnt);
        return (cnt == '0) ? BURSTW'(1) : cnt;
    endfunction

endpackage

// File: rtl/jtframe_ddram_bram.sv
// Single-port byte-enabled RAM with a registered read (one cycle latency, read-before-write).
module jtframe_ddram_bram #(
    parameter int DW    = 64,
    parameter int MEMAW = 10
)(
    input  logic             clk,
    input  logic [MEMAW-1:0] addr,
    input  logic             we,
    input  logic [DW/8-1:0]  be,
    input  logic [DW-1:0]    din,
    output logic [DW-1:0]    q
);

    logic [DW-1:0] mem [0:2**MEMAW-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DW/8; i++)
            if (we && be[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
        q <= mem[addr];
    end

endmodule

// File: rtl/jtframe_ddram_resp.sv
// ddram_* burst responder backed by on-chip BRAM instead of DDR3.
// Optional JTFRAME_DDRAM_RESP_WAIT_EN inserts WAIT busy cycles (WAIT >= 1) before reads and after writes.
module jtframe_ddram_resp
    import jtframe_ddram_pkg::*;
#(
    parameter int AW    = 29,
    parameter int DW    = 64,
    parameter int MEMAW = 10,
    parameter int WAIT  = 3
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ddram_addr,
    input  logic [7:0]      ddram_burstcnt,
    input  logic            ddram_rd,
    input  logic            ddram_we,
    input  logic [DW-1:0]   ddram_din,
    input  logic [DW/8-1:0] ddram_be,
    output logic            ddram_busy,
    output logic [DW-1:0]   ddram_dout,
    output logic            ddram_dout_ready,
    output logic            proto_err
);

    localparam int STAGES = 1;

    ddram_st_e         st, st_nx;
    logic [MEMAW-1:0]  ptr, ptr_nx, mem_addr;
    logic [BURSTW-1:0] rcnt, rcnt_nx, nbeats;
    logic              err_nx, mem_we, rd_issue;
    logic [STAGES:0]   vld_pipe;
    logic [DW-1:0]     mem_q;
`ifdef JTFRAME_DDRAM_RESP_WAIT_EN
    logic [7:0]        wcnt, wcnt_nx;
    logic              wt_rd, wt_rd_nx;
`endif

    // Upper address bits alias onto the BRAM.
    logic unused_cfg;
    assign unused_cfg = ^ddram_addr[AW-1:MEMAW] ^ (WAIT != 0);

    assign nbeats           = norm_burst(ddram_burstcnt);
    assign ddram_busy       = (st == RD) || (st == WT);
    assign ddram_dout_ready = vld_pipe[STAGES];

    always_comb begin
        st_nx    = st;
        ptr_nx   = ptr;
        rcnt_nx  = rcnt;
        err_nx   = proto_err;
        mem_we   = 1'b0;
        rd_issue = 1'b0;
        mem_addr = ptr;
`ifdef JTFRAME_DDRAM_RESP_WAIT_EN
        wcnt_nx  = wcnt;
        wt_rd_nx = wt_rd;
`endif
        case (st)
            IDLE: begin
                mem_addr = ddram_addr[MEMAW-1:0];
                if (ddram_we) begin
                    mem_we  = 1'b1;
                    ptr_nx  = mem_addr + 1'b1;
                    rcnt_nx = nbeats - 1'b1;
                    err_nx  = proto_err | ddram_rd;
                    if (nbeats != BURSTW'(1)) st_nx = WR;
`ifdef JTFRAME_DDRAM_RESP_WAIT_EN
                    else begin
                        st_nx    = WT;
                        wcnt_nx  = 8'(WAIT);
                        wt_rd_nx = 1'b0;
                    end
`endif
                end else if (ddram_rd) begin
`ifdef JTFRAME_DDRAM_RESP_WAIT_EN
                    st_nx    = WT;
                    ptr_nx   = mem_addr;
                    rcnt_nx  = nbeats;
                    wcnt_nx  = 8'(WAIT);
                    wt_rd_nx = 1'b1;
`else
                    // First beat is read on the acceptance edge itself.
                    st_nx    = RD;
                    rd_issue = 1'b1;
                    ptr_nx   = mem_addr + 1'b1;
                    rcnt_nx  = nbeats - 1'b1;
`endif
                end
            end
            WR: begin
                err_nx = proto_err | ddram_rd;
                if (ddram_we) begin
                    mem_we  = 1'b1;
                    ptr_nx  = ptr + 1'b1;
                    rcnt_nx = rcnt - 1'b1;
                    if (rcnt == BURSTW'(1)) begin
`ifdef JTFRAME_DDRAM_RESP_WAIT_EN
                        st_nx    = WT;
                        wcnt_nx  = 8'(WAIT);
                        wt_rd_nx = 1'b0;
`else
                        st_nx    = IDLE;
`endif
                    end
                end
            end
            RD: begin
                if (rcnt != '0) begin
                    rd_issue = 1'b1;
                    ptr_nx   = ptr + 1'b1;
                    rcnt_nx  = rcnt - 1'b1;
                end else if (!vld_pipe[0]) begin
                    st_nx = IDLE;
                end
            end
`ifdef JTFRAME_DDRAM_RESP_WAIT_EN
            WT: begin
                wcnt_nx = wcnt - 1'b1;
                if (wcnt == 8'd1) begin
                    if (wt_rd) begin
                        st_nx    = RD;
                        rd_issue = 1'b1;
                        ptr_nx   = ptr + 1'b1;
                        rcnt_nx  = rcnt - 1'b1;
                    end else begin
                        st_nx    = IDLE;
                    end
                end
            end
`endif
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            ptr        <= '0;
            rcnt       <= '0;
            proto_err  <= 1'b0;
            vld_pipe   <= '0;
            ddram_dout <= '0;
`ifdef JTFRAME_DDRAM_RESP_WAIT_EN
            wcnt       <= '0;
            wt_rd      <= 1'b0;
`endif
        end else begin
            st        <= st_nx;
            ptr       <= ptr_nx;
            rcnt      <= rcnt_nx;
            proto_err <= err_nx;
            vld_pipe  <= {vld_pipe[STAGES-1:0], rd_issue};
            if (vld_pipe[0]) ddram_dout <= mem_q;
`ifdef JTFRAME_DDRAM_RESP_WAIT_EN
            wcnt      <= wcnt_nx;
            wt_rd     <= wt_rd_nx;
`endif
        end
    end

    jtframe_ddram_bram #(.DW(DW), .MEMAW(MEMAW)) u_bram (
        .clk  (clk),
        .addr (mem_addr),
        .we   (mem_we),
        .be   (ddram_be),
        .din  (ddram_din),
        .q    (mem_q)
    );

endmodule

// File: tb/tb_jtframe_ddram_resp.sv
// Scoreboard bench for jtframe_ddram_resp: directed bursts, beat data and beat timing checked by a monitor.
module tb_jtframe_ddram_resp;

    localparam int AW = 29, DW = 64, MEMAW = 10, WAIT = 3;
`ifdef JTFRAME_DDRAM_RESP_WAIT_EN
    localparam int LAT = WAIT;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0, rst = 1'b1;
    logic [AW-1:0] ddram_addr = '0;
    logic [7:0]    ddram_burstcnt = '0;
    logic          ddram_rd = 1'b0, ddram_we = 1'b0;
    logic [DW-1:0] ddram_din = '0;
    logic [7:0]    ddram_be = '0;
    logic          ddram_busy, ddram_dout_ready, proto_err;
    logic [DW-1:0] ddram_dout;

    jtframe_ddram_resp #(.AW(AW), .DW(DW), .MEMAW(MEMAW), .WAIT(WAIT)) dut (
        .clk              (clk),
        .rst              (rst),
        .ddram_addr       (ddram_addr),
        .ddram_burstcnt   (ddram_burstcnt),
        .ddram_rd         (ddram_rd),
        .ddram_we         (ddram_we),
        .ddram_din        (ddram_din),
        .ddram_be         (ddram_be),
        .ddram_busy       (ddram_busy),
        .ddram_dout       (ddram_dout),
        .ddram_dout_ready (ddram_dout_ready),
        .proto_err        (proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    typedef struct { logic [63:0] data; int at; } exp_t;
    exp_t sb[$];

    logic [63:0] wd[8];
    logic [7:0]  wbe[8];
    logic [63:0] rexp[8];

    // Each read beat must match the oldest expectation in data and in cycle.
    always @(negedge clk) begin
        exp_t e;
        if (ddram_dout_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %h at cycle %0d, no beat expected", ddram_dout, cyc);
            end else begin
                e = sb.pop_front();
                if (ddram_dout !== e.data || cyc != e.at) begin
                    errors++;
                    $display("FAIL rd_beat: got %h at cycle %0d, expected %h at cycle %0d",
                             ddram_dout, cyc, e.data, e.at);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (ddram_busy && n < 600) begin
            tick;
            n++;
        end
        if (ddram_busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic wr_burst(input int addr, input int n, input int bc);
        int nb;
        ddram_addr     = AW'(addr);
        ddram_burstcnt = 8'(bc);
        for (int k = 0; k < n; k++) begin
            ddram_we  = 1'b1;
            ddram_din = wd[k];
            ddram_be  = wbe[k];
            tick;
            ddram_addr = '0;
        end
        ddram_we = 1'b0;
        wait_idle(nb);
        chk("wr_tail_busy", 64'(nb), 64'(LAT));
    endtask

    task automatic rd_burst(input int addr, input int bc, input int n, input int npush, input bit do_wait);
        int t, nb;
        exp_t e;
        ddram_addr     = AW'(addr);
        ddram_burstcnt = 8'(bc);
        ddram_rd       = 1'b1;
        tick;
        t = cyc;
        ddram_rd   = 1'b0;
        ddram_addr = '0;
        for (int k = 0; k < npush; k++) begin
            e.data = rexp[k];
            e.at   = t + 1 + LAT + k;
            sb.push_back(e);
        end
        if (do_wait) begin
            wait_idle(nb);
            chk("rd_busy_span", 64'(nb), 64'(n + 1 + LAT));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1);
    end

    initial begin
        int nb;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(ddram_busy), 64'd0);
        chk("rst_dout", ddram_dout, 64'd0);
        chk("rst_ready", 64'(ddram_dout_ready), 64'd0);
        chk("rst_err", 64'(proto_err), 64'd0);
        rst = 1'b0;
        tick;

        // Single write then single read
        wd[0] = 64'h0123_4567_89AB_CDEF; wbe[0] = 8'hFF;
        wr_burst(5, 1, 1);
        rexp[0] = 64'h0123_4567_89AB_CDEF;
        rd_burst(5, 1, 1, 1, 1);

        // Prefill, then a 4-beat write with a partial byte enable on beat 2
        for (int k = 0; k < 4; k++) begin wd[k] = '1; wbe[k] = 8'hFF; end
        wr_burst(8, 4, 4);
        wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
        wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
        wbe[1] = 8'h0F;
        wr_burst(8, 4, 4);
        rexp[0] = 64'h1111_1111_1111_1111; rexp[1] = 64'hFFFF_FFFF_2222_2222;
        rexp[2] = 64'h3333_3333_3333_3333; rexp[3] = 64'h4444_4444_4444_4444;
        rd_burst(8, 4, 4, 4, 1);

        // burstcnt 0 means one beat
        wd[0] = 64'hDEAD_BEEF_0000_0014; wbe[0] = 8'hFF;
        wr_burst(20, 1, 0);
        rexp[0] = 64'hDEAD_BEEF_0000_0014;
        rd_burst(20, 0, 1, 1, 1);
        chk("err_clean", 64'(proto_err), 64'd0);

        // Wrap across the top of memory and aliasing of upper address bits
        wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; wd[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        wd[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        for (int k = 0; k < 3; k++) wbe[k] = 8'hFF;
        wr_burst(1022, 3, 3);
        rexp[0] = 64'hBBBB_BBBB_BBBB_BBBB;
        rd_burst(1024 + 1023, 1, 1, 1, 1);
        rexp[0] = 64'hBBBB_BBBB_BBBB_BBBB; rexp[1] = 64'hCCCC_CCCC_CCCC_CCCC;
        rd_burst(1023, 2, 2, 2, 1);
        rexp[0] = 64'hCCCC_CCCC_CCCC_CCCC;
        rd_burst(1024, 1, 1, 1, 1);

        // rd and we together in IDLE: write wins, no beats, sticky error
        ddram_addr = 30; ddram_burstcnt = 1; ddram_din = 64'h5555_6666_7777_8888; ddram_be = 8'hFF;
        ddram_we = 1'b1; ddram_rd = 1'b1;
        tick;
        ddram_we = 1'b0; ddram_rd = 1'b0;
        wait_idle(nb);
        repeat (4) tick;
        chk("err_rdwe", 64'(proto_err), 64'd1);
        rexp[0] = 64'h5555_6666_7777_8888;
        rd_burst(30, 1, 1, 1, 1);
        chk("err_sticky", 64'(proto_err), 64'd1);

        // rd during WR, with an idle gap between beats
        rst = 1'b1; tick; rst = 1'b0; tick;
        chk("err_after_rst", 64'(proto_err), 64'd0);
        ddram_addr = 40; ddram_burstcnt = 3; ddram_be = 8'hFF;
        ddram_we = 1'b1; ddram_din = 64'h6000_0000_0000_0001;
        tick;
        ddram_we = 1'b0; ddram_rd = 1'b1; ddram_addr = '0;
        tick;
        chk("wr_busy_low", 64'(ddram_busy), 64'd0);
        ddram_rd = 1'b0; ddram_we = 1'b1; ddram_din = 64'h6000_0000_0000_0002;
        tick;
        ddram_din = 64'h6000_0000_0000_0003;
        tick;
        ddram_we = 1'b0;
        wait_idle(nb);
        chk("err_rd_in_wr", 64'(proto_err), 64'd1);
        rexp[0] = 64'h6000_0000_0000_0001; rexp[1] = 64'h6000_0000_0000_0002;
        rexp[2] = 64'h6000_0000_0000_0003;
        rd_burst(40, 3, 3, 3, 1);

        // Reset during the second beat of an 8-beat read
        rexp[0] = 64'h1111_1111_1111_1111; rexp[1] = 64'hFFFF_FFFF_2222_2222;
        rd_burst(8, 8, 8, 2, 0);
        repeat (2 + LAT) tick;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(ddram_dout_ready), 64'd0);
        chk("rst_mid_busy", 64'(ddram_busy), 64'd0);
        chk("rst_mid_beats", 64'(sb.size()), 64'd0);
        tick;
        rst = 1'b0;
        repeat (5) tick;
        rexp[0] = 64'h0123_4567_89AB_CDEF;
        rd_burst(5, 1, 1, 1, 1);

        // 2-beat write (tail busy equals WAIT when the wait feature is on)
        wd[0] = 64'h7777_0000_0000_0032; wd[1] = 64'h7777_0000_0000_0033;
        wbe[0] = 8'hFF; wbe[1] = 8'hFF;
        wr_burst(50, 2, 2);
        rexp[0] = 64'h7777_0000_0000_0032; rexp[1] = 64'h7777_0000_0000_0033;
        rd_burst(50, 2, 2, 2, 1);

        repeat (5) tick;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
